// File: rtl/rv_pkg.sv
// Shared decode constants and types for the RV32 decode/issue slice.
// Field positions, R-type encodings and the ALU operation enum.
package rv_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_XOR   = 3'b100;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_ILLEGAL
    } alu_op_t;

    function automatic alu_op_t decode_op(input logic [31:0] w);
        logic [9:0] key;
        alu_op_t    op;
        key = {w[F7_LSB +: 7], w[F3_LSB +: 3]};
        op  = ALU_ILLEGAL;
        if (w[OPC_LSB +: 7] == OP_RTYPE) begin
            case (key)
                {F7_BASE, F3_ADD}: op = ALU_ADD;
                {F7_ALT,  F3_ADD}: op = ALU_SUB;
                {F7_BASE, F3_AND}: op = ALU_AND;
                {F7_BASE, F3_OR }: op = ALU_OR;
                {F7_BASE, F3_XOR}: op = ALU_XOR;
                default:           op = ALU_ILLEGAL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32-entry 2R1W register file; x0 reads zero and a same-cycle
// write is forwarded to the read ports.
module rv_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem_q [32];
    logic            wr;

    assign wr = we && (waddr != 5'd0);

    // Storage is intentionally unreset: in-flight writebacks survive reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem_q[raddr1];
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (wr && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = mem_q[raddr2];
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (wr && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/rv_decode_issue.sv
// Decode/issue stage: R-type decode, operand read, busy scoreboard
// and in-flight limit in front of a non-stalling ALU.
module rv_decode_issue
    import rv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int INFLIGHT_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            issue_valid,
    output logic [6:0]      OPCODE,
    output logic [6:0]      FUNC7,
    output logic [2:0]      FUNC3,
    output logic [XLEN-1:0] OP1,
    output logic [XLEN-1:0] OP2,
    output logic [4:0]      issue_rd,
    output logic            illegal_instr
);

    localparam logic [3:0] MAX_CNT = 4'(INFLIGHT_MAX);

    logic [4:0]      rd, rs1, rs2;
    logic            legal, hazard, room;
    logic            issue_fire, ill_fire;
    logic [31:0]     wb_mask, busy_live;
    logic [XLEN-1:0] rdata1, rdata2;

    logic [31:0]     busy_q, busy_d;
    logic [3:0]      count_q, count_d;
    logic            valid_q, valid_d;
    logic            illegal_q, illegal_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [6:0]      func7_q, func7_d;
    logic [2:0]      func3_q, func3_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [4:0]      rd_q, rd_d;

    assign rd    = instr[RD_LSB +: 5];
    assign rs1   = instr[RS1_LSB +: 5];
    assign rs2   = instr[RS2_LSB +: 5];
    assign legal = decode_op(instr) != ALU_ILLEGAL;

    rv_regfile #(.XLEN(XLEN)) u_rf (
        .clk    (clk),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Hazards see the scoreboard after this cycle's writeback clear.
    assign wb_mask   = wb_en ? (32'd1 << wb_rd) : 32'd0;
    assign busy_live = busy_q & ~wb_mask;
    assign hazard    = busy_live[rs1] | busy_live[rs2] | busy_live[rd];
    assign room      = (count_q < MAX_CNT) | wb_en;

    assign instr_ready = rst_n & (!legal | (!hazard & room));
    assign issue_fire  = instr_valid & instr_ready & legal;
    assign ill_fire    = instr_valid & instr_ready & !legal;

    always_comb begin
        busy_d    = busy_live;
        count_d   = count_q;
        valid_d   = issue_fire;
        illegal_d = ill_fire;
        opcode_d  = opcode_q;
        func7_d   = func7_q;
        func3_d   = func3_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        rd_d      = rd_q;
        if (issue_fire && (rd != 5'd0)) begin
            busy_d[rd] = 1'b1;
        end
        if (issue_fire && !wb_en) begin
            count_d = count_q + 4'd1;
        end else if (!issue_fire && wb_en && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
        if (issue_fire) begin
            opcode_d = instr[OPC_LSB +: 7];
            func7_d  = instr[F7_LSB +: 7];
            func3_d  = instr[F3_LSB +: 3];
            op1_d    = rdata1;
            op2_d    = rdata2;
            rd_d     = rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            opcode_q  <= '0;
            func7_q   <= '0;
            func3_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            opcode_q  <= opcode_d;
            func7_q   <= func7_d;
            func3_q   <= func3_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_q      <= rd_d;
        end
    end

    assign issue_valid   = valid_q;
    assign illegal_instr = illegal_q;
    assign OPCODE        = opcode_q;
    assign FUNC7         = func7_q;
    assign FUNC3         = func3_q;
    assign OP1           = op1_q;
    assign OP2           = op2_q;
    assign issue_rd      = rd_q;

endmodule

// File: tb/tb_rv_decode_issue.sv
// Bench for rv_decode_issue: directed scenarios then random traffic
// against an array/queue reference model.
module tb_rv_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic [6:0]  OPCODE;
    logic [6:0]  FUNC7;
    logic [2:0]  FUNC3;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [4:0]  issue_rd;
    logic        illegal_instr;

    rv_decode_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .issue_valid   (issue_valid),
        .OPCODE        (OPCODE),
        .FUNC7         (FUNC7),
        .FUNC3         (FUNC3),
        .OP1           (OP1),
        .OP2           (OP2),
        .issue_rd      (issue_rd),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          m_cnt;
    logic        e_iv, e_ill;
    logic [6:0]  e_opc, e_f7;
    logic [2:0]  e_f3;
    logic [31:0] e_op1, e_op2;
    logic [4:0]  e_rd;
    logic        last_ready;

    // ADD, SUB, AND, OR, XOR
    function automatic logic [31:0] mk(int k, int rd, int rs1, int rs2);
        logic [6:0] f7t [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        logic [2:0] f3t [5] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4};
        return {f7t[k], 5'(rs2), 5'(rs1), f3t[k], 5'(rd), 7'h33};
    endfunction

    function automatic bit ref_legal(logic [31:0] w);
        for (int k = 0; k < 5; k++)
            if (w == mk(k, w[11:7], w[19:15], w[24:20])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rval(logic [4:0] r, logic we,
                                         logic [4:0] wr, logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (we && wr == r) return wd;
        return m_regs[r];
    endfunction

    task automatic step(input logic v, input logic [31:0] ins,
                        input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, output bit took);
        logic [4:0] rd, rs1, rs2;
        bit leg, haz, rdy;
        bit b [32];
        instr_valid = v;
        instr       = ins;
        wb_en       = we;
        wb_rd       = wrd;
        wb_data     = wd;
        @(negedge clk);
        rd  = ins[11:7];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        leg = ref_legal(ins);
        b   = m_busy;
        if (we) b[wrd] = 1'b0;
        haz = b[rs1] || b[rs2] || b[rd];
        rdy = !leg || (!haz && (m_cnt < 4 || we));
        chk("instr_ready", instr_ready, rdy);
        last_ready = instr_ready;
        took  = v && rdy;
        e_iv  = took && leg;
        e_ill = took && !leg;
        if (e_iv) begin
            e_opc = ins[6:0];
            e_f7  = ins[31:25];
            e_f3  = ins[14:12];
            e_rd  = rd;
            e_op1 = rval(rs1, we, wrd, wd);
            e_op2 = rval(rs2, we, wrd, wd);
        end
        if (we && wrd != 0) m_regs[wrd] = wd;
        m_busy = b;
        if (e_iv && rd != 0) m_busy[rd] = 1'b1;
        if (e_iv) begin
            if (!we) m_cnt++;
        end else if (we && m_cnt > 0) begin
            m_cnt--;
        end
        @(posedge clk);
        #1;
        chk("issue_valid", issue_valid, e_iv);
        chk("illegal_instr", illegal_instr, e_ill);
        chk("fields", {OPCODE, FUNC7, FUNC3, issue_rd},
            {e_opc, e_f7, e_f3, e_rd});
        chk("op1", OP1, e_op1);
        chk("op2", OP2, e_op2);
    endtask

    task automatic reset_chk();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_illegal", illegal_instr, 0);
        chk("rst_fields", {OPCODE, FUNC7, FUNC3, issue_rd}, 0);
        chk("rst_op1", OP1, 0);
        chk("rst_op2", OP2, 0);
        chk("rst_ready", instr_ready, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_cnt = 0;
        e_iv  = 0;
        e_ill = 0;
        e_opc = 0;
        e_f7  = 0;
        e_f3  = 0;
        e_rd  = 0;
        e_op1 = 0;
        e_op2 = 0;
    endtask

    // Asserted mid-cycle, away from any clock edge
    task automatic reset_mid();
        instr_valid = 0;
        wb_en       = 0;
        #2 rst_n = 1'b0;
        #1;
        reset_chk();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    bit          tk;
    logic        v, we;
    logic [4:0]  wrd;
    logic [31:0] ins, wd;
    logic [4:0]  pend [$];

    initial begin
        rst_n       = 1'b0;
        instr_valid = 0;
        instr       = 0;
        wb_en       = 0;
        wb_rd       = 0;
        wb_data     = 0;
        m_regs[0]   = 0;
        model_reset();
        #3;
        reset_chk();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload x1..x31
        for (int r = 1; r < 32; r++) begin
            wd = (r == 1) ? 32'd5 : (r == 2) ? 32'd7 : $urandom;
            step(0, 0, 1, 5'(r), wd, tk);
        end

        step(1, mk(0, 3, 1, 2), 0, 0, 0, tk);
        chk("add_issue", issue_valid, 1);
        chk("add_fields", {OPCODE, FUNC7, FUNC3, issue_rd},
            {7'h33, 7'h00, 3'd0, 5'd3});
        chk("add_op1", OP1, 5);
        chk("add_op2", OP2, 7);

        step(1, mk(1, 4, 3, 1), 0, 0, 0, tk);
        chk("sub_stall", last_ready, 0);
        step(1, mk(1, 4, 3, 1), 1, 3, 12, tk);
        chk("sub_released", last_ready, 1);
        chk("sub_op1", OP1, 12);
        step(0, 0, 1, 4, 7, tk);

        for (int r = 5; r <= 8; r++) step(1, mk(0, r, 1, 2), 0, 0, 0, tk);
        step(1, mk(0, 9, 1, 2), 0, 0, 0, tk);
        chk("cnt_stall", last_ready, 0);
        step(1, mk(0, 9, 1, 2), 1, 5, 32'h55, tk);
        chk("cnt_release", issue_valid, 1);
        for (int r = 6; r <= 9; r++) step(0, 0, 1, 5'(r), $urandom, tk);

        step(1, 32'h00000013, 0, 0, 0, tk);
        chk("addi_illegal", illegal_instr, 1);
        chk("addi_no_issue", issue_valid, 0);
        step(0, 0, 0, 0, 0, tk);
        chk("addi_pulse", illegal_instr, 0);

        step(1, mk(0, 0, 1, 2), 0, 0, 0, tk);
        step(1, mk(0, 10, 0, 1), 0, 0, 0, tk);
        chk("x0_no_busy", last_ready, 1);
        chk("x0_op1", OP1, 0);
        step(0, 0, 1, 0, 32'hFFFF_FFFF, tk);
        step(1, mk(0, 11, 0, 0), 1, 10, 32'h1234, tk);
        chk("x0_kept_op1", OP1, 0);
        chk("x0_kept_op2", OP2, 0);
        step(0, 0, 1, 11, $urandom, tk);

        step(1, mk(0, 12, 1, 2), 0, 0, 0, tk);
        step(1, mk(0, 13, 1, 2), 0, 0, 0, tk);
        reset_mid();
        step(1, mk(0, 12, 12, 1), 0, 0, 0, tk);
        chk("post_rst_no_stall", last_ready, 1);
        step(0, 0, 1, 13, 32'hABCD, tk);
        step(0, 0, 1, 12, 32'h4321, tk);
        step(1, mk(2, 14, 13, 12), 0, 0, 0, tk);
        chk("late_wb_op1", OP1, 32'hABCD);
        step(0, 0, 1, 14, $urandom, tk);

        for (int c = 0; c < 3000; c++) begin
            we  = 0;
            wrd = 0;
            wd  = $urandom;
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                int i;
                i   = $urandom_range(0, pend.size() - 1);
                wrd = pend[i];
                pend.delete(i);
                we  = 1;
            end
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) != 0)
                ins = mk($urandom_range(0, 4), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 7));
            else if ($urandom_range(0, 1) == 1)
                ins = {$urandom} & 32'hFFFF_FF80 | 32'h13;
            else
                ins = mk(0, $urandom_range(0, 7), 1, 2) | 32'h0200_0000;
            step(v, ins, we, wrd, wd, tk);
            if (tk && ref_legal(ins)) pend.push_back(ins[11:7]);
            if (c == 1500) begin
                reset_mid();
                pend.delete();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
